// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch side drives req/addr; memory returns gnt, rvalid and rdata.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// holds the returned instruction until accepted, and counts retired instructions.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    instr_fetch_if.master   imem,
    output logic [XLEN-1:0] Instr,
    output logic            InstrValid,
    input  logic            InstrReady,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            MisalignErr,
    output logic [31:0]     InstRet
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic            req;
    logic            valid;
    logic            accept;
    logic [XLEN-1:0] pc_nxt;

    assign PCPlus4    = PC + XLEN'(4);
    assign pc_nxt     = PCSrc ? {PCTarget[XLEN-1:2], 2'b00} : PCPlus4;
    assign imem.req   = req;
    assign imem.addr  = PC;
    assign InstrValid = valid;

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        valid     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // rvalid is ignored here so a response from an aborted request cannot leak in
                req = 1'b1;
                if (imem.gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem.rvalid) state_nxt = HOLD;
            end
            HOLD: begin
                valid = 1'b1;
                if (InstrReady) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            Instr       <= '0;
            MisalignErr <= 1'b0;
            InstRet     <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && imem.rvalid) Instr <= imem.rdata;
            if (accept) begin
                PC      <= pc_nxt;
                InstRet <= InstRet + 32'd1;
                if (PCSrc && (PCTarget[1:0] != 2'b00)) MisalignErr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetch transactions driven through a small
// imem responder, with expected instructions queued on response and popped on InstrValid.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr, PC, PCPlus4, PCTarget, InstRet;
    logic        InstrValid, InstrReady, PCSrc, MisalignErr;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem       (bus),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .MisalignErr(MisalignErr),
        .InstRet    (InstRet)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gnt_dly;
        int          ready_dly;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] ret_exp = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch_one(input vec_t v);
        bit          ok;
        exp_t        e;
        logic [31:0] held;
        wait_req(ok);
        if (!ok) return;
        check("imem_addr", bus.addr, v.exp_addr);
        for (int i = 0; i < v.gnt_dly; i++) begin
            tick();
            check("req_held", {31'd0, bus.req}, 32'd1);
            check("addr_stable", bus.addr, v.exp_addr);
            check("no_valid_before_gnt", {31'd0, InstrValid}, 32'd0);
        end
        bus.gnt = 1'b1;
        tick();
        bus.gnt = 1'b0;
        check("req_low_in_wait", {31'd0, bus.req}, 32'd0);
        sb.push_back('{pc: v.exp_addr, instr: mem(v.exp_addr)});
        bus.rvalid = 1'b1;
        bus.rdata  = mem(v.exp_addr);
        tick();
        bus.rvalid = 1'b0;
        check("instr_valid", {31'd0, InstrValid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("instr", Instr, e.instr);
        check("pc", PC, e.pc);
        check("pcplus4", PCPlus4, e.pc + 32'd4);
        held = Instr;
        for (int i = 0; i < v.ready_dly; i++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hDEAD_0000 + 32'(i);
            tick();
            check("hold_instr", Instr, held);
            check("hold_pc", PC, e.pc);
            check("hold_no_req", {31'd0, bus.req}, 32'd0);
            check("hold_instret", InstRet, ret_exp);
            check("hold_valid", {31'd0, InstrValid}, 32'd1);
        end
        bus.rvalid = 1'b0;
        InstrReady = 1'b1;
        PCSrc      = v.src;
        PCTarget   = v.tgt;
        tick();
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'hFFFF_FFFF;
        ret_exp    = ret_exp + 32'd1;
        check("instret", InstRet, ret_exp);
        check("misalign", {31'd0, MisalignErr}, {31'd0, v.exp_mis});
        check("valid_drop", {31'd0, InstrValid}, 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_req", {31'd0, bus.req}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_pc", PC, 32'h0000_0100);
        check("rst_instr", Instr, 32'd0);
        check("rst_instret", InstRet, 32'd0);
        check("rst_misalign", {31'd0, MisalignErr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0100, 1'b0};
        vecs[1] = '{0, 0, 1'b0, 32'h0,         32'h0000_0104, 1'b0};
        vecs[2] = '{0, 0, 1'b1, 32'h0000_0200, 32'h0000_0108, 1'b0};
        vecs[3] = '{5, 0, 1'b0, 32'h0,         32'h0000_0200, 1'b0};
        vecs[4] = '{0, 4, 1'b0, 32'h0,         32'h0000_0204, 1'b0};
        vecs[5] = '{0, 0, 1'b1, 32'h0000_0203, 32'h0000_0208, 1'b1};
        vecs[6] = '{0, 0, 1'b0, 32'h0,         32'h0000_0200, 1'b1};
        vecs[7] = '{0, 0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0204, 1'b1};
        vecs[8] = '{0, 0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1};
        vecs[9] = '{0, 0, 1'b0, 32'h0,         32'h0000_0000, 1'b1};

        reset_n    = 1'b0;
        InstrReady = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'd0;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'd0;
        tick();
        tick();
        check_reset_state();
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) fetch_one(vecs[i]);

        // Reset while waiting for rvalid; a late response must not be captured
        wait_req(ok);
        if (ok) begin
            bus.gnt = 1'b1;
            tick();
            bus.gnt = 1'b0;
            reset_n = 1'b0;
            tick();
            check_reset_state();
            ret_exp    = 0;
            reset_n    = 1'b1;
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hBAD0_BAD0;
            tick();
            check("rearm_req", {31'd0, bus.req}, 32'd1);
            check("rearm_addr", bus.addr, 32'h0000_0100);
            check("late_rvalid_valid", {31'd0, InstrValid}, 32'd0);
            tick();
            bus.rvalid = 1'b0;
            check("late_rvalid_instr", Instr, 32'd0);
            check("late_rvalid_valid2", {31'd0, InstrValid}, 32'd0);
            fetch_one('{0, 0, 1'b0, 32'h0, 32'h0000_0100, 1'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
